// File: rtl/mod_fetch_unit.sv
// Fetch stage: PC register, credit-limited imem requests, in-order tag queue,
// and a 2-entry {pc, instr} buffer toward decode with redirect flush.
module mod_fetch_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        branch_taken,
  input  logic [31:0] branch_address,
  output logic [31:0] pc_plus_4,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        misaligned
);

  logic [31:0] pc;
  logic [1:0]  outstanding;
  logic [1:0]  drop_count;
  logic [1:0]  buf_count;
  logic [31:0] tag_q [2];
  logic        tag_wr;
  logic        tag_rd;
  logic [31:0] buf_pc [2];
  logic [31:0] buf_instr [2];
  logic        buf_hd;
  logic        buf_tl;
  logic        credit_ok;
  logic        req_fire;
  logic        rsp_keep;
  logic        pop;

  assign pc_plus_4     = pc + 32'd4;
  assign imem_req_addr = pc;
  assign credit_ok     = ({1'b0, outstanding} + {1'b0, buf_count}) < 3'd2;
  assign imem_req_valid = !rst && !branch_taken && credit_ok;
  assign req_fire      = imem_req_valid && imem_req_ready;
  // A response landing in the redirect cycle belongs to the old stream.
  assign rsp_keep      = imem_rsp_valid && !branch_taken && (drop_count == 2'd0);
  assign if_valid      = buf_count != 2'd0;
  assign pop           = if_valid && if_ready && !branch_taken;
  assign if_pc         = buf_pc[buf_hd];
  assign if_instr      = buf_instr[buf_hd];

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_VECTOR;
    end else if (branch_taken) begin
      pc <= {branch_address[31:2], 2'b00};
    end else if (req_fire) begin
      pc <= pc_plus_4;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      outstanding <= 2'd0;
      drop_count  <= 2'd0;
    end else begin
      outstanding <= outstanding + 2'(req_fire) - 2'(imem_rsp_valid);
      if (branch_taken) begin
        drop_count <= outstanding - 2'(imem_rsp_valid);
      end else if (imem_rsp_valid && drop_count != 2'd0) begin
        drop_count <= drop_count - 2'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_wr <= 1'b0;
      tag_rd <= 1'b0;
      for (int i = 0; i < 2; i++) tag_q[i] <= '0;
    end else begin
      if (req_fire) begin
        tag_q[tag_wr] <= pc;
        tag_wr        <= ~tag_wr;
      end
      if (imem_rsp_valid) tag_rd <= ~tag_rd;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_count <= 2'd0;
      buf_hd    <= 1'b0;
      buf_tl    <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        buf_pc[i]    <= '0;
        buf_instr[i] <= '0;
      end
    end else if (branch_taken) begin
      buf_count <= 2'd0;
      buf_hd    <= 1'b0;
      buf_tl    <= 1'b0;
    end else begin
      if (rsp_keep) begin
        buf_pc[buf_tl]    <= tag_q[tag_rd];
        buf_instr[buf_tl] <= imem_rsp_data;
        buf_tl            <= ~buf_tl;
      end
      if (pop) buf_hd <= ~buf_hd;
      buf_count <= buf_count + 2'(rsp_keep) - 2'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) misaligned <= 1'b0;
    else     misaligned <= branch_taken && (|branch_address[1:0]);
  end

endmodule

// File: tb/tb_mod_fetch_unit.sv
// Bench for mod_fetch_unit: latency-configurable imem model plus
// in-order {pc, instr} scoreboard filled on each request handshake.
module tb_mod_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_address = '0;
  logic [31:0] pc_plus_4;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b1;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data = '0;
  logic        if_valid;
  logic        if_ready = 1'b1;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        misaligned;

  logic [31:0] w_pc_plus_4;
  logic        w_req_valid;
  logic [31:0] w_req_addr;
  logic        w_rsp_valid = 1'b0;
  logic [31:0] w_rsp_data = '0;
  logic        w_if_valid;
  logic [31:0] w_if_pc;
  logic [31:0] w_if_instr;
  logic        w_misaligned;

  int checks = 0;
  int failures = 0;
  int delivered = 0;
  int lat = 1;
  int unsigned cyc = 0;
  logic [31:0] exp_pc = '0;

  typedef struct {
    int unsigned due;
    logic [31:0] addr;
  } mreq_t;

  mreq_t       mq[$];
  logic [63:0] sb[$];

  mod_fetch_unit u_dut (
    .clk(clk), .rst(rst),
    .branch_taken(branch_taken), .branch_address(branch_address),
    .pc_plus_4(pc_plus_4),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .if_valid(if_valid), .if_ready(if_ready),
    .if_pc(if_pc), .if_instr(if_instr), .misaligned(misaligned)
  );

  mod_fetch_unit #(.RESET_VECTOR(32'hFFFF_FFFC)) u_wrap (
    .clk(clk), .rst(rst),
    .branch_taken(branch_taken), .branch_address(branch_address),
    .pc_plus_4(w_pc_plus_4),
    .imem_req_valid(w_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(w_req_addr),
    .imem_rsp_valid(w_rsp_valid), .imem_rsp_data(w_rsp_data),
    .if_valid(w_if_valid), .if_ready(if_ready),
    .if_pc(w_if_pc), .if_instr(w_if_instr), .misaligned(w_misaligned)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] memword(input logic [31:0] a);
    return {~a[15:0], a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Memory model and scoreboard act just before the coming edge.
  always @(negedge clk) begin
    mreq_t       m;
    logic [63:0] e;
    if (rst) begin
      mq.delete();
      sb.delete();
      exp_pc = 32'h0;
      imem_rsp_valid = 1'b0;
      imem_rsp_data = '0;
    end else begin
      if (mq.size() > 0 && mq[0].due == cyc + 1) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data = memword(mq[0].addr);
        void'(mq.pop_front());
      end else begin
        imem_rsp_valid = 1'b0;
        imem_rsp_data = '0;
      end
      if (branch_taken) begin
        sb.delete();
        exp_pc = {branch_address[31:2], 2'b00};
      end else if (if_valid && if_ready) begin
        checks++;
        delivered++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL deliver_extra: got pc=%h instr=%h, expected none",
                   if_pc, if_instr);
        end else begin
          e = sb.pop_front();
          if ({if_pc, if_instr} !== e) begin
            failures++;
            $display("FAIL deliver: got pc=%h instr=%h, expected pc=%h instr=%h",
                     if_pc, if_instr, e[63:32], e[31:0]);
          end
        end
      end
      if (imem_req_valid && imem_req_ready) begin
        checks++;
        if (imem_req_addr !== exp_pc) begin
          failures++;
          $display("FAIL req_addr: got %h, expected %h", imem_req_addr, exp_pc);
        end
        exp_pc = exp_pc + 32'd4;
        m.due = cyc + 1 + lat;
        m.addr = imem_req_addr;
        mq.push_back(m);
        sb.push_back({imem_req_addr, memword(imem_req_addr)});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    branch_taken = 1'b0;
    tick();
    tick();
    rst = 1'b0;
    #1;
  endtask

  task automatic wait_valid(input logic [31:0] want, input string name);
    int n;
    n = 0;
    while (!if_valid && n < 40) begin
      tick();
      n++;
    end
    checks++;
    if (!if_valid) begin
      failures++;
      $display("FAIL %s: if_valid never rose, expected pc=%h", name, want);
    end else if (if_pc !== want) begin
      failures++;
      $display("FAIL %s: got if_pc=%h, expected %h", name, if_pc, want);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    checks++;
    if ({if_valid, if_pc, if_instr} !== 65'd0) begin
      failures++;
      $display("FAIL reset_if: got v=%b pc=%h instr=%h, expected 0/0/0",
               if_valid, if_pc, if_instr);
    end
    checks++;
    if ({imem_req_valid, misaligned} !== 2'b00) begin
      failures++;
      $display("FAIL reset_flags: got req_valid=%b misaligned=%b, expected 0 0",
               imem_req_valid, misaligned);
    end
    checks++;
    if (imem_req_addr !== 32'h0 || pc_plus_4 !== 32'h4) begin
      failures++;
      $display("FAIL reset_pc: got addr=%h pc4=%h, expected 0 4",
               imem_req_addr, pc_plus_4);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (imem_req_valid !== 1'b1) begin
      failures++;
      $display("FAIL first_req: got req_valid=%b, expected 1", imem_req_valid);
    end
  endtask

  task automatic test_stream();
    int d0;
    lat = 1;
    if_ready = 1'b1;
    imem_req_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (!imem_req_valid || imem_req_addr !== 32'(4 * i) ||
          pc_plus_4 !== 32'(4 * i + 4)) begin
        failures++;
        $display("FAIL stream_req%0d: got v=%b addr=%h pc4=%h, expected 1 %h %h",
                 i, imem_req_valid, imem_req_addr, pc_plus_4, 4 * i, 4 * i + 4);
      end
      tick();
    end
    checks++;
    if (!if_valid || if_pc !== 32'h0 || if_instr !== memword(32'h0)) begin
      failures++;
      $display("FAIL stream_first: got v=%b pc=%h instr=%h, expected 1 0 %h",
               if_valid, if_pc, if_instr, memword(32'h0));
    end
    d0 = delivered;
    repeat (20) tick();
    checks++;
    if (delivered - d0 < 8) begin
      failures++;
      $display("FAIL stream_rate: got %0d deliveries in 20 cycles, expected >= 8",
               delivered - d0);
    end
  endtask

  task automatic test_stall();
    int d0;
    lat = 1;
    if_ready = 1'b0;
    imem_req_ready = 1'b1;
    do_reset();
    repeat (10) tick();
    checks++;
    if (imem_req_valid !== 1'b0 || !if_valid || if_pc !== 32'h0) begin
      failures++;
      $display("FAIL stall_full: got req_valid=%b v=%b pc=%h, expected 0 1 0",
               imem_req_valid, if_valid, if_pc);
    end
    d0 = delivered;
    imem_req_ready = 1'b0;
    if_ready = 1'b1;
    repeat (6) tick();
    checks++;
    if (delivered - d0 != 2 || sb.size() != 0 || if_valid !== 1'b0) begin
      failures++;
      $display("FAIL stall_drain: got %0d delivered, %0d pending, v=%b, expected 2 0 0",
               delivered - d0, sb.size(), if_valid);
    end
    imem_req_ready = 1'b1;
  endtask

  task automatic test_redirect();
    lat = 3;
    if_ready = 1'b1;
    do_reset();
    tick();
    tick();
    branch_taken = 1'b1;
    branch_address = 32'h0000_0100;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL redir_noreq: got req_valid=%b, expected 0", imem_req_valid);
    end
    tick();
    branch_taken = 1'b0;
    #1;
    checks++;
    if (imem_req_addr !== 32'h0000_0100) begin
      failures++;
      $display("FAIL redir_addr: got %h, expected 00000100", imem_req_addr);
    end
    wait_valid(32'h0000_0100, "redir_first");
    lat = 1;
  endtask

  task automatic test_redirect_collide();
    lat = 1;
    if_ready = 1'b1;
    do_reset();
    tick();
    tick();
    branch_taken = 1'b1;
    branch_address = 32'h0000_0200;
    @(negedge clk);
    #1;
    checks++;
    if (imem_rsp_valid !== 1'b1 || if_valid !== 1'b1 || imem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL collide_pre: got rsp=%b v=%b req=%b, expected 1 1 0",
               imem_rsp_valid, if_valid, imem_req_valid);
    end
    tick();
    branch_taken = 1'b0;
    #1;
    checks++;
    if (if_valid !== 1'b0) begin
      failures++;
      $display("FAIL collide_flush: got if_valid=%b, expected 0", if_valid);
    end
    wait_valid(32'h0000_0200, "collide_first");
  endtask

  task automatic test_misaligned();
    lat = 1;
    if_ready = 1'b1;
    do_reset();
    branch_taken = 1'b1;
    branch_address = 32'h0000_0106;
    #1;
    checks++;
    if (imem_req_valid !== 1'b0) begin
      failures++;
      $display("FAIL mis_noreq: got req_valid=%b, expected 0", imem_req_valid);
    end
    tick();
    branch_taken = 1'b0;
    #1;
    checks++;
    if (misaligned !== 1'b1 || imem_req_addr !== 32'h0000_0104 || !imem_req_valid) begin
      failures++;
      $display("FAIL mis_pulse: got mis=%b addr=%h v=%b, expected 1 00000104 1",
               misaligned, imem_req_addr, imem_req_valid);
    end
    tick();
    checks++;
    if (misaligned !== 1'b0) begin
      failures++;
      $display("FAIL mis_clear: got %b, expected 0", misaligned);
    end
    wait_valid(32'h0000_0104, "mis_first");
  endtask

  task automatic test_wrap();
    imem_req_ready = 1'b1;
    do_reset();
    checks++;
    if (!w_req_valid || w_req_addr !== 32'hFFFF_FFFC || w_pc_plus_4 !== 32'h0) begin
      failures++;
      $display("FAIL wrap_first: got v=%b addr=%h pc4=%h, expected 1 fffffffc 0",
               w_req_valid, w_req_addr, w_pc_plus_4);
    end
    tick();
    checks++;
    if (w_req_addr !== 32'h0) begin
      failures++;
      $display("FAIL wrap_next: got %h, expected 0", w_req_addr);
    end
  endtask

  task automatic test_reset_mid();
    lat = 1;
    if_ready = 1'b0;
    do_reset();
    repeat (5) tick();
    checks++;
    if (if_valid !== 1'b1) begin
      failures++;
      $display("FAIL midrst_pre: got if_valid=%b, expected 1", if_valid);
    end
    rst = 1'b1;
    tick();
    checks++;
    if ({if_valid, if_pc, if_instr, misaligned, imem_req_valid} !== 67'd0 ||
        imem_req_addr !== 32'h0 || pc_plus_4 !== 32'h4) begin
      failures++;
      $display("FAIL midrst: got v=%b pc=%h instr=%h mis=%b req=%b addr=%h pc4=%h, expected all 0, pc4=4",
               if_valid, if_pc, if_instr, misaligned, imem_req_valid,
               imem_req_addr, pc_plus_4);
    end
    rst = 1'b0;
    if_ready = 1'b1;
    tick();
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_redirect();
    test_redirect_collide();
    test_misaligned();
    test_wrap();
    test_reset_mid();
    repeat (5) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
